// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O block: data width,
// register word offsets (mem_adrM[7:2]) and STATUS bit positions.
package mmio_uart_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] IO_STATUS  = 6'h00;
    localparam logic [5:0] IO_RXDATA  = 6'h01;
    localparam logic [5:0] IO_TXDATA  = 6'h02;
    localparam logic [5:0] IO_CYCLE   = 6'h04;
    localparam logic [5:0] IO_INSTR   = 6'h05;
    localparam logic [5:0] IO_CTR_RST = 6'h06;

    localparam int unsigned ST_TX_NFULL  = 0;
    localparam int unsigned ST_RX_NEMPTY = 1;
    localparam int unsigned ST_TX_OVF    = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is refused when full and
// pop when empty, judged on the current count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; contents are only visible once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// I/O region decoder behind the M-stage data port: UART RX/TX FIFOs,
// cycle/instruction counters and a one-cycle registered read path.
module mmio_uart_ctrl
    import mmio_uart_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [3:0]  IO_BASE_NIB = 4'h8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] mem_adrM,
    input  logic [XLEN-1:0] mem_wdataM,
    input  logic [3:0]      wea,
    input  logic            mem_reM,
    input  logic            instr_retire,
    output logic [XLEN-1:0] io_rdata,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready
);

    logic            hit;
    logic [5:0]      offset;
    logic            rd_hit;
    logic            tx_push;
    logic            tx_pop;
    logic            tx_full;
    logic            tx_empty;
    logic            rx_push;
    logic            rx_pop;
    logic            rx_full;
    logic            rx_empty;
    logic [7:0]      rx_head;
    logic            ctr_clr;
    logic            ovf_set;
    logic            ovf_clr;
    logic            tx_ovf;
    logic [XLEN-1:0] cycle_cnt;
    logic [XLEN-1:0] instr_cnt;
    logic [XLEN-1:0] rdata_next;
    logic            unused_bits;

    assign hit     = (mem_adrM[31:28] == IO_BASE_NIB);
    assign offset  = mem_adrM[7:2];
    assign rd_hit  = mem_reM & hit;

    assign tx_push = hit & (offset == IO_TXDATA) & wea[0];
    assign tx_pop  = tx_valid & tx_ready;
    assign ovf_set = tx_push & tx_full;
    assign ovf_clr = rd_hit & (offset == IO_STATUS);
    assign ctr_clr = hit & (offset == IO_CTR_RST) & (|wea);

    assign rx_ready = rst & ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rd_hit & (offset == IO_RXDATA) & ~rx_empty;

    assign tx_valid = ~tx_empty;

    assign unused_bits = ^{mem_adrM[27:8], mem_adrM[1:0], mem_wdataM[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (mem_wdataM[7:0]),
        .pop   (tx_pop),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        rdata_next = '0;
        if (hit) begin
            case (offset)
                IO_STATUS: begin
                    rdata_next[ST_TX_NFULL]  = ~tx_full;
                    rdata_next[ST_RX_NEMPTY] = ~rx_empty;
                    rdata_next[ST_TX_OVF]    = tx_ovf;
                end
                IO_RXDATA: if (!rx_empty) rdata_next = {24'b0, rx_head};
                IO_CYCLE:  rdata_next = cycle_cnt;
                IO_INSTR:  rdata_next = instr_cnt;
                default:   rdata_next = '0;
            endcase
        end
    end

    // Set has priority so an overflow coinciding with a STATUS read is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ovf <= 1'b0;
        end else begin
            tx_ovf <= ovf_set | (tx_ovf & ~ovf_clr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (ctr_clr) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (instr_retire) instr_cnt <= instr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_rdata <= '0;
        end else if (mem_reM) begin
            io_rdata <= rdata_next;
        end
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed and randomized checks of mmio_uart_ctrl against a queue-based
// model of its register map, FIFOs and counters.
module tb_mmio_uart_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  wea;
    logic        re;
    logic        retire;
    logic [31:0] io_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int total = 0;
    int bad   = 0;

    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic [31:0] m_cyc;
    logic [31:0] m_ins;
    logic [31:0] m_rdata;
    logic        m_ovf;

    always #5 clk = ~clk;

    mmio_uart_ctrl #(.FIFO_DEPTH(DEPTH), .IO_BASE_NIB(4'h8)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_adrM     (adr),
        .mem_wdataM   (wdata),
        .wea          (wea),
        .mem_reM      (re),
        .instr_retire (retire),
        .io_rdata     (io_rdata),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_cyc   = '0;
        m_ins   = '0;
        m_ovf   = 1'b0;
        m_rdata = '0;
    endtask

    task automatic idle();
        adr    = '0;
        wdata  = '0;
        wea    = '0;
        re     = 1'b0;
        retire = 1'b0;
    endtask

    task automatic load(input logic [7:0] off);
        idle();
        adr = 32'h8000_0000 | {24'd0, off};
        re  = 1'b1;
    endtask

    task automatic store(input logic [7:0] off, input logic [31:0] d);
        idle();
        adr   = 32'h8000_0000 | {24'd0, off};
        wdata = d;
        wea   = 4'b0001;
    endtask

    // Advance one clock: predict from the register-map rules, then compare.
    task automatic cycle();
        logic       hit;
        logic [5:0] off;
        int         tx_n;
        int         rx_n;
        logic       ovf_set;
        hit     = (adr[31:28] == 4'h8);
        off     = adr[7:2];
        tx_n    = txq.size();
        rx_n    = rxq.size();
        ovf_set = 1'b0;
        if (re) begin
            if (!hit) m_rdata = '0;
            else case (off)
                6'd0: m_rdata = {29'd0, m_ovf, rx_n != 0, tx_n != DEPTH};
                6'd1: m_rdata = (rx_n != 0) ? {24'd0, rxq[0]} : 32'd0;
                6'd4: m_rdata = m_cyc;
                6'd5: m_rdata = m_ins;
                default: m_rdata = '0;
            endcase
        end
        if (tx_ready && tx_n > 0) void'(txq.pop_front());
        if (hit && off == 6'd2 && wea[0]) begin
            if (tx_n == DEPTH) ovf_set = 1'b1;
            else txq.push_back(wdata[7:0]);
        end
        if (re && hit && off == 6'd1 && rx_n > 0) void'(rxq.pop_front());
        if (rx_valid && rx_n < DEPTH) rxq.push_back(rx_data);
        m_ovf = ovf_set | (m_ovf & !(re && hit && off == 6'd0));
        if (hit && off == 6'd6 && wea != 4'd0) begin
            m_cyc = '0;
            m_ins = '0;
        end else begin
            m_cyc = m_cyc + 32'd1;
            if (retire) m_ins = m_ins + 32'd1;
        end
        @(posedge clk);
        #1;
        chk("io_rdata", io_rdata, m_rdata);
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, txq.size() != 0});
        if (txq.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, txq[0]});
        chk("rx_ready", {31'd0, rx_ready}, {31'd0, rxq.size() != DEPTH});
    endtask

    initial begin
        int         need;
        logic [3:0] nib;
        rst      = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_io_rdata", io_rdata, 32'd0);
        chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("in_reset_rx_ready", {31'd0, rx_ready}, 32'd0);
        rst = 1'b1;
        model_reset();
        cycle();

        // TX ordering and drain
        store(8'h08, 32'h0000_0041); cycle();
        store(8'h08, 32'hDEAD_BE42); cycle();
        idle();
        chk("tx_head_first", {24'd0, tx_data}, 32'h41);
        tx_ready = 1'b1; cycle();
        chk("tx_head_second", {24'd0, tx_data}, 32'h42);
        cycle();
        chk("tx_drained", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Reset mid-run with three bytes queued
        for (int i = 0; i < 3; i++) begin
            store(8'h08, 32'(i + 1)); cycle();
        end
        load(8'h10); cycle();
        idle();
        rst = 1'b0;
        #1;
        chk("midreset_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("midreset_io_rdata", io_rdata, 32'd0);
        chk("midreset_rx_ready", {31'd0, rx_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        cycle();
        load(8'h10); cycle();
        chk("cycle_after_reset", io_rdata, 32'd1);

        // TX overflow and sticky flag clear-on-read
        for (int i = 0; i < DEPTH + 1; i++) begin
            store(8'h08, 32'($urandom)); cycle();
        end
        load(8'h00); cycle();
        chk("status_overflow", io_rdata, 32'h4);
        cycle();
        chk("status_ovf_cleared", io_rdata, 32'h0);
        idle();
        tx_ready = 1'b1;
        repeat (DEPTH) cycle();
        tx_ready = 1'b0;

        // RX path
        idle();
        rx_valid = 1'b1; rx_data = 8'h55; cycle();
        rx_data = 8'hAA; cycle();
        rx_valid = 1'b0;
        load(8'h00); cycle();
        chk("status_rx", io_rdata, 32'h3);
        load(8'h04); cycle();
        chk("rx_first", io_rdata, 32'h55);
        cycle();
        chk("rx_second", io_rdata, 32'hAA);
        cycle();
        chk("rx_empty_read", io_rdata, 32'h0);
        idle();
        rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 8'($urandom); cycle();
        end
        chk("rx_full_ready", {31'd0, rx_ready}, 32'd0);
        rx_data = 8'hEE; cycle();
        rx_valid = 1'b0;
        load(8'h04);
        repeat (DEPTH + 1) cycle();

        // Counters
        store(8'h18, 32'h1); cycle();
        idle();
        need = 60;
        for (int i = 0; i < 100; i++) begin
            retire = ($urandom_range(0, 99 - i) < need);
            if (retire) need--;
            cycle();
        end
        load(8'h10); cycle();
        chk("cycle_100", io_rdata, 32'd100);
        load(8'h14); cycle();
        chk("instr_60", io_rdata, 32'd60);
        store(8'h18, 32'hF000_0000);
        wea    = 4'b1000;
        retire = 1'b1;
        cycle();
        load(8'h14); cycle();
        chk("instr_after_clr", io_rdata, 32'd0);
        load(8'h10); cycle();
        chk("cycle_after_clr", io_rdata, 32'd1);

        // Counter wrap
        idle();
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        m_cyc = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        load(8'h10); cycle();
        chk("cycle_max", io_rdata, 32'hFFFF_FFFF);
        cycle();
        chk("cycle_wrapped", io_rdata, 32'd0);

        // Decode: non-hit load and store
        load(8'h10); cycle();
        idle();
        adr = 32'h0000_0010; re = 1'b1; cycle();
        chk("nonhit_load", io_rdata, 32'd0);
        idle();
        adr = 32'h0000_0008; wdata = 32'h77; wea = 4'hF; cycle();
        idle(); cycle();
        chk("nonhit_store", {31'd0, tx_valid}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            idle();
            if ($urandom_range(0, 9) < 8) begin
                adr = {4'h8, 20'($urandom), 6'($urandom_range(0, 8)), 2'($urandom)};
            end else begin
                nib = 4'($urandom_range(0, 14));
                if (nib >= 4'h8) nib = nib + 4'd1;
                adr = {nib, 28'($urandom)};
            end
            re       = ($urandom_range(0, 1) == 1);
            wea      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            wdata    = $urandom;
            retire   = ($urandom_range(0, 1) == 1);
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 1) == 1);
            rx_data  = 8'($urandom);
            cycle();
        end
        idle();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
